iob_eth_tx_framer: RTL

- Upstream stage of the Ethernet transmitter.
- Accepts a payload byte stream and writes a complete frame image into the byte-wide TX frame buffer:
  - preamble, SFD, destination MAC, source MAC, EtherType, then payload.
  - Pads short payloads to the Ethernet minimum.
- Presents the padded payload length and a one-cycle send pulse to the transmitter, then waits for the transmitter to finish before accepting the next frame.

---
 rtl/iob_eth_tx_framer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/iob_eth_tx_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iob_eth_tx_framer: builds preamble/SFD/MAC/EtherType/payload frame image |
// | in the TX buffer, pads to minimum length and hands off to the MAC.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module iob_eth_tx_framer #(
    parameter int ADDR_W      = 11,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [47:0]       dst_mac,
    input  logic [47:0]       src_mac,
    input  logic [15:0]       eth_type,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic [ADDR_W-1:0] tx_nbytes,
    output logic              tx_send,
    input  logic              tx_ready,
    output logic              busy,
    output logic              err_oversize
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DROP    = 3'd3,
        ST_PAD     = 3'd4,
        ST_SEND    = 3'd5,
        ST_WAIT_LO = 3'd6,
        ST_WAIT_HI = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] c_HDR_LEN  = ADDR_W'(22);
    localparam logic [ADDR_W-1:0] c_MIN      = ADDR_W'(MIN_PAYLOAD);
    localparam logic [ADDR_W-1:0] c_MAX      = ADDR_W'(MAX_PAYLOAD);
    localparam logic [4:0]        c_HDR_LAST = 5'd21;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [4:0]          hdr_idx_q, hdr_idx_d;
    logic [175:0]        hdr_q, hdr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                in_ready_q, in_ready_d;
    logic [ADDR_W-1:0]   nbytes_q, nbytes_d;
    logic                send_q, send_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                accept;
    logic [ADDR_W-1:0]   count_inc;

    assign accept    = in_valid && in_ready_q;
    assign count_inc = count_q + ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hdr_idx_d = hdr_idx_q;
        hdr_d     = hdr_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        nbytes_d  = nbytes_q;
        send_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (in_valid && tx_ready) begin
                    // Whole header is snapshotted here and shifted out MSB byte first
                    hdr_d     = {{7{8'h55}}, 8'hD5, dst_mac, src_mac, eth_type};
                    hdr_idx_d = '0;
                    state_d   = ST_HDR;
                end
            end
            ST_HDR: begin
                we_d      = 1'b1;
                addr_d    = ADDR_W'(hdr_idx_q);
                wdata_d   = hdr_q[175:168];
                hdr_d     = {hdr_q[167:0], 8'h00};
                hdr_idx_d = hdr_idx_q + 5'd1;
                if (hdr_idx_q == c_HDR_LAST) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = c_HDR_LEN + count_q;
                    wdata_d = in_data;
                    count_d = count_inc;
                    if (in_last) begin
                        state_d = (count_inc < c_MIN) ? ST_PAD : ST_SEND;
                    end else if (count_inc == c_MAX) begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (accept && in_last) begin
                    state_d = ST_SEND;
                end
            end
            ST_PAD: begin
                we_d    = 1'b1;
                addr_d  = c_HDR_LEN + count_q;
                wdata_d = 8'h00;
                count_d = count_inc;
                if (count_inc >= c_MIN) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                nbytes_d = count_q;
                send_d   = 1'b1;
                state_d  = ST_WAIT_LO;
            end
            // Low phase first: the transmitter's ready flag lags our send pulse
            ST_WAIT_LO: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_PAYLOAD) || (state_d == ST_DROP);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            hdr_idx_q  <= '0;
            hdr_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            nbytes_q   <= '0;
            send_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hdr_idx_q  <= hdr_idx_d;
            hdr_q      <= hdr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            nbytes_q   <= nbytes_d;
            send_q     <= send_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign buf_we       = we_q;
    assign buf_addr     = addr_q;
    assign buf_wdata    = wdata_q;
    assign tx_nbytes    = nbytes_q;
    assign tx_send      = send_q;
    assign busy         = busy_q;
    assign err_oversize = err_q;

endmodule
`default_nettype wire
